// File: rtl/bp_update_queue.sv
// Compacting FIFO feeding committed conditional branches to the predictor, one training beat per cycle.
// Latency: a branch committed in cycle N appears on update_* in N+1; commit_ready low unless a full group fits.
module bp_update_queue #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [COMMIT_WIDTH-1:0]              commit_valid,
  input  logic [COMMIT_WIDTH-1:0]              commit_is_br,
  input  logic [COMMIT_WIDTH-1:0]              commit_taken,
  input  logic [COMMIT_WIDTH-1:0][31:0]        commit_pc,
  output logic                                 commit_ready,
  output logic                                 update_en,
  output logic [31:0]                          update_pc,
  output logic                                 update_taken,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy,
  output logic [31:0]                          br_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [COMMIT_WIDTH-1:0] lane_en;
  logic [OW-1:0] lane_off [COMMIT_WIDTH];
  logic [OW-1:0] n_enq;
  entry_t        head_ent;

  // Depends on registered occupancy only, so the ROB sees no combinational path from its own commits.
  assign commit_ready = (OW'(DEPTH) - occupancy) >= OW'(COMMIT_WIDTH);

  // Each accepted lane lands at tail plus the number of accepted lanes below it.
  always_comb begin
    n_enq   = '0;
    lane_en = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_en[i]  = commit_valid[i] & commit_is_br[i] & commit_ready;
      lane_off[i] = n_enq;
      if (lane_en[i]) begin
        n_enq = n_enq + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (lane_en[i] && !rst) begin
        mem[tail + PW'(lane_off[i])] <= '{pc: commit_pc[i], taken: commit_taken[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      br_count  <= '0;
    end else begin
      tail      <= tail + PW'(n_enq);
      head      <= head + PW'(update_en);
      occupancy <= occupancy + n_enq - OW'(update_en);
      br_count  <= br_count + 32'(update_en);
    end
  end

  assign head_ent     = mem[head];
  assign update_en    = (occupancy != '0);
  assign update_pc    = update_en ? head_ent.pc : 32'd0;
  assign update_taken = update_en & head_ent.taken;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue: queue-based reference model checked every cycle plus literal spot checks.
module tb_bp_update_queue;

  localparam int CW    = 2;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [CW-1:0]    commit_valid;
  logic [CW-1:0]    commit_is_br;
  logic [CW-1:0]    commit_taken;
  logic [CW-1:0][31:0] commit_pc;
  logic             commit_ready;
  logic             update_en;
  logic [31:0]      update_pc;
  logic             update_taken;
  logic [3:0]       occupancy;
  logic [31:0]      br_count;

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic        tk;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_cnt = '0;

  bp_update_queue #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_is_br (commit_is_br),
    .commit_taken (commit_taken),
    .commit_pc    (commit_pc),
    .commit_ready (commit_ready),
    .update_en    (update_en),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .occupancy    (occupancy),
    .br_count     (br_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; pop the head each busy cycle, push accepted branches in lane order.
  always @(posedge clk) begin
    bit rdy;
    if (rst) begin
      q.delete();
      m_cnt = '0;
    end else begin
      rdy = (DEPTH - q.size()) >= CW;
      if (q.size() > 0) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 32'd1;
      end
      if (rdy) begin
        for (int i = 0; i < CW; i++) begin
          if (commit_valid[i] && commit_is_br[i]) q.push_back('{pc: commit_pc[i], tk: commit_taken[i]});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("update_en",    32'(update_en),    32'(q.size() > 0));
      chk("update_pc",    update_pc,         (q.size() > 0) ? q[0].pc : 32'd0);
      chk("update_taken", 32'(update_taken), (q.size() > 0) ? 32'(q[0].tk) : 32'd0);
      chk("occupancy",    32'(occupancy),    32'(q.size()));
      chk("commit_ready", 32'(commit_ready), 32'((DEPTH - q.size()) >= CW));
      chk("br_count",     br_count,          m_cnt);
    end
  end

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] b, input logic [1:0] t,
                       input logic [31:0] p0, input logic [31:0] p1);
    rst          = r;
    commit_valid = v;
    commit_is_br = b;
    commit_taken = t;
    commit_pc[0] = p0;
    commit_pc[1] = p1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; commit_valid = '0; commit_is_br = '0; commit_taken = '0; commit_pc = '0;
    drive(1'b1, 2'b11, 2'b11, 2'b11, 32'hdead, 32'hbeef);
    chk_on = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0);
    chk("reset update_en",    32'(update_en),    32'd0);
    chk("reset occupancy",    32'(occupancy),    32'd0);
    chk("reset commit_ready", 32'(commit_ready), 32'd1);
    chk("reset br_count",     br_count,          32'd0);

    // Single branch: visible exactly one cycle later
    drive(1'b0, 2'b01, 2'b01, 2'b01, 32'h1000, 32'd0);
    chk("single en",    32'(update_en),    32'd1);
    chk("single pc",    update_pc,         32'h1000);
    chk("single taken", 32'(update_taken), 32'd1);
    idle(1);
    chk("single drained", 32'(update_en), 32'd0);
    chk("single count",   br_count,        32'd1);

    // Compaction: only lane1 is a branch
    drive(1'b0, 2'b11, 2'b10, 2'b00, 32'h3000, 32'h2004);
    chk("compact occ", 32'(occupancy), 32'd1);
    chk("compact pc",  update_pc,      32'h2004);
    idle(1);
    chk("compact occ0", 32'(occupancy), 32'd0);

    // Fill: two branches per cycle; seventh group hits commit_ready=0 and is dropped
    for (int k = 0; k < 6; k++)
      drive(1'b0, 2'b11, 2'b11, 2'(k), 32'h4000 + 32'(16 * k), 32'h4008 + 32'(16 * k));
    chk("fill occ7",  32'(occupancy),    32'd7);
    chk("fill ready", 32'(commit_ready), 32'd0);
    drive(1'b0, 2'b11, 2'b11, 2'b11, 32'h5000, 32'h5004);
    chk("ignored commit occ", 32'(occupancy), 32'd6);
    idle(10);

    // Wrap-around: 20 branches in pairs, respecting commit_ready
    for (int i = 0; i < 20; ) begin
      if (commit_ready) begin
        drive(1'b0, 2'b11, 2'b11, 2'b10, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * (i + 1)));
        i += 2;
      end else begin
        idle(1);
      end
    end
    idle(12);
    chk("wrap occ0",  32'(occupancy), 32'd0);
    chk("wrap count", br_count,       32'd34);

    // Reset with five entries queued; commits during reset are ignored
    for (int k = 0; k < 4; k++) drive(1'b0, 2'b11, 2'b11, 2'b01, 32'h6000 + 32'(8 * k), 32'h6004 + 32'(8 * k));
    chk("pre-reset occ", 32'(occupancy), 32'd5);
    drive(1'b1, 2'b11, 2'b11, 2'b11, 32'h7000, 32'h7004);
    chk("mid reset en",    32'(update_en),    32'd0);
    chk("mid reset occ",   32'(occupancy),    32'd0);
    chk("mid reset count", br_count,          32'd0);
    chk("mid reset ready", 32'(commit_ready), 32'd1);
    chk("mid reset pc",    update_pc,         32'd0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bp_update_queue.md
BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

Interface
REQ-001 Parameter COMMIT_WIDTH, default 2, SHALL set the number of ROB commit lanes presented per cycle.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count (power of two, DEPTH >= 2*COMMIT_WIDTH).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 commit_valid  input  COMMIT_WIDTH  per-lane instruction retiring this cycle.
REQ-006 commit_is_br  input  COMMIT_WIDTH  per-lane retiring instruction is a conditional branch.
REQ-007 commit_taken  input  COMMIT_WIDTH  per-lane resolved branch direction (1 = taken).
REQ-008 commit_pc  input  COMMIT_WIDTH x 32  per-lane branch PC.
REQ-009 commit_ready  output  1  queue can absorb a full commit group this cycle.
REQ-010 update_en  output  1  predictor training beat valid; drives update_en of the cb side of cb_bp_itf.
REQ-011 update_pc  output  32  PC of training beat; drives pc of cb_bp_itf.
REQ-012 update_taken  output  1  direction of training beat; drives branch_taken of cb_bp_itf.
REQ-013 occupancy  output  $clog2(DEPTH+1)  current entry count.
REQ-014 br_count  output  32  total training beats issued since reset.

Function
REQ-015 The block SHALL be a circular FIFO of {pc[31:0], taken} entries with head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-016 commit_ready SHALL be 1 iff (DEPTH - occupancy) >= COMMIT_WIDTH, computed combinationally from registered state only.
REQ-017 A lane SHALL be enqueued iff commit_valid & commit_is_br & commit_ready; lanes with commit_ready = 0 are ignored (ROB contract: no commit while not ready).
REQ-018 Enqueued lanes SHALL be written in ascending lane index into consecutive tail slots; non-branch or invalid lanes consume no slot (compaction, gaps allowed anywhere).
REQ-019 Tail SHALL advance by the number of lanes enqueued (0..COMMIT_WIDTH), modulo DEPTH.
REQ-020 update_en SHALL be 1 iff occupancy != 0; update_pc/update_taken SHALL equal the head entry when update_en = 1 and 0 when update_en = 0.
REQ-021 The predictor accepts every beat; when update_en = 1 the head SHALL advance by one at the clock edge (one beat per cycle, no backpressure).
REQ-022 Enqueue-to-update latency SHALL be exactly 1 cycle when the queue is empty (no bypass: a branch committed in cycle N appears on update_* in cycle N+1).
REQ-023 Training beats SHALL leave in exact program (commit) order; no reordering, drop, or duplication.
REQ-024 Simultaneous enqueue and dequeue: occupancy_next = occupancy + n_enq - (update_en ? 1 : 0); never exceeds DEPTH, never underflows.
REQ-025 Enqueue into the slot being dequeued in the same cycle is legal only after wrap with occupancy = DEPTH - n; write uses tail, read uses head, no collision possible by REQ-016.
REQ-026 br_count SHALL increment by 1 on every cycle update_en = 1, wrapping 2^32-1 -> 0.
REQ-027 Pipeline flushes SHALL NOT affect queue contents (entries are architecturally committed).

Reset
REQ-028 On rst = 1 at a clock edge: head = tail = 0, occupancy = 0, br_count = 0; next cycle update_en = 0, update_pc = 0, update_taken = 0, commit_ready = 1.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries, with no update_en beat in the cycle following reset; commit inputs during rst are ignored.
REQ-030 Entry storage needs no reset; only pointers, occupancy and br_count are reset.

Verification
REQ-031 Single branch: lane0 valid/is_br, pc=0x1000, taken=1 in cycle 0 -> cycle 1 update_en=1, update_pc=0x1000, update_taken=1; cycle 2 update_en=0; br_count=1.
REQ-032 Compaction: lane0 non-branch, lane1 branch pc=0x2004 taken=0 -> exactly one beat pc=0x2004 taken=0; occupancy peaks at 1.
REQ-033 Fill/backpressure: 2 branches/cycle for 7 cycles (DEPTH=8) -> commit_ready drops to 0 when occupancy reaches 7; beats emerge in order, one per cycle, none lost.
REQ-034 Wrap-around: push/pop 20 branches with PCs 0x100+4*i, alternating taken -> output sequence identical, pointers wrap at 8, occupancy returns to 0.
REQ-035 Reset mid-stream: rst with occupancy=5 -> next cycle update_en=0, occupancy=0, br_count=0, commit_ready=1.
REQ-036 Ignored commit: commit_valid=2'b11, commit_is_br=2'b11 while commit_ready=0 -> occupancy unchanged except the one dequeued beat.
